// File: rtl/bakery_arb_pkg.sv
// -----------------------------------------------------------------------------
// bakery_arb_pkg
// Shared types and configuration checks for the bakery ticket arbiter.
//   arb_state   : per-requester state (IDLE -> WAIT -> CRIT -> IDLE)
//   arb_cfg_ok  : elaboration-time legality check of the arbiter parameters
// -----------------------------------------------------------------------------
package bakery_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CRIT = 2'd2
    } arb_state;

    // Tickets must never alias among outstanding requesters (2**tkw > nproc),
    // and the owner field must be able to name every requester.
    function automatic bit arb_cfg_ok(input int nproc, input int tkw,
                                      input int idw, input int hold_max);
        return (nproc >= 1) && ((1 << tkw) > nproc) &&
               ((1 << idw) >= nproc) && (hold_max >= 1);
    endfunction

endpackage

// File: rtl/bakery_ticket_dispenser.sv
// -----------------------------------------------------------------------------
// bakery_ticket_dispenser
// Hands out consecutive tickets to every requester leaving IDLE on this edge,
// lower index first.
//   take_i    : requesters taking a ticket this cycle
//   next_tk_i : first free ticket number
//   tk_o      : per-requester ticket (next_tk_i + lower-index takes), mod 2**TKW
//   adv_o     : number of tickets issued this cycle
// -----------------------------------------------------------------------------
module bakery_ticket_dispenser #(
    parameter int NPROC = 4,
    parameter int TKW   = 4
) (
    input  logic [NPROC-1:0]          take_i,
    input  logic [TKW-1:0]            next_tk_i,
    output logic [NPROC-1:0][TKW-1:0] tk_o,
    output logic [TKW-1:0]            adv_o
);

    logic [TKW-1:0] cnt;

    // Running prefix popcount; cannot overflow because NPROC < 2**TKW.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NPROC; i++) begin
            tk_o[i] = next_tk_i + cnt;
            if (take_i[i]) begin
                cnt = cnt + TKW'(1);
            end
        end
        adv_o = cnt;
    end

endmodule

// File: rtl/bakery_arbiter.sv
// -----------------------------------------------------------------------------
// bakery_arbiter
// Ticket (bakery) arbiter granting one shared resource to NPROC requesters in
// ticket order; simultaneous arrivals are ordered by lower index first.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   req       : per-requester request level, held until granted
//   rel       : per-requester release pulse, valid only while granted
//   grant     : registered one-hot (or zero) grant
//   owner     : index of the granted requester, 0 when idle
//   busy      : any grant active
//   proto_err : sticky protocol-violation flag
// Optional feature: define BAKERY_ARB_TIMEOUT_EN to force-release an owner
// that holds the grant for HOLD_MAX cycles without rel.
// -----------------------------------------------------------------------------
module bakery_arbiter #(
    parameter int NPROC    = 4,
    parameter int TKW      = 4,
    parameter int IDW      = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NPROC-1:0] req,
    input  logic [NPROC-1:0] rel,
    output logic [NPROC-1:0] grant,
    output logic [IDW-1:0]   owner,
    output logic             busy,
    output logic             proto_err
);

    import bakery_arb_pkg::*;

    if (!arb_cfg_ok(NPROC, TKW, IDW, HOLD_MAX)) begin : g_cfg_err
        $error("bakery_arbiter: need 2**TKW > NPROC, 2**IDW >= NPROC, HOLD_MAX >= 1");
    end

    arb_state                  state_q [NPROC];
    arb_state                  state_d [NPROC];
    logic [NPROC-1:0][TKW-1:0] tk_q, tk_d, disp_tk;
    logic [TKW-1:0]            next_tk_q, next_tk_d, adv;
    logic [TKW-1:0]            serving_q, serving_d;
    logic [NPROC-1:0]          take;
    logic [NPROC-1:0]          grant_q, grant_d;
    logic [IDW-1:0]            owner_q, owner_d;
    logic                      busy_q, busy_d;
    logic                      perr_q, perr_d;
    logic                      any_crit;
    logic                      hold_expired;

    always_comb begin
        take     = '0;
        any_crit = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            take[i] = (state_q[i] == IDLE) && req[i];
            if (state_q[i] == CRIT) begin
                any_crit = 1'b1;
            end
        end
    end

    bakery_ticket_dispenser #(
        .NPROC (NPROC),
        .TKW   (TKW)
    ) u_dispenser (
        .take_i    (take),
        .next_tk_i (next_tk_q),
        .tk_o      (disp_tk),
        .adv_o     (adv)
    );

`ifdef BAKERY_ARB_TIMEOUT_EN
    localparam int HCW = $clog2(HOLD_MAX + 1);
    logic [HCW-1:0] hold_q, hold_d;

    // Zero on the grant edge (nobody was in CRIT), then counts CRIT cycles.
    assign hold_d       = any_crit ? hold_q + HCW'(1) : '0;
    assign hold_expired = (hold_q == HCW'(HOLD_MAX - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tk_d      = tk_q;
        serving_d = serving_q;
        perr_d    = perr_q;
        next_tk_d = next_tk_q + adv;
        for (int i = 0; i < NPROC; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (req[i]) begin
                        state_d[i] = WAIT;
                        tk_d[i]    = disp_tk[i];
                    end
                end
                WAIT: begin
                    // A dropped request keeps its ticket; only flagged.
                    if (!req[i]) begin
                        perr_d = 1'b1;
                    end
                    // Tickets are unique, so at most one waiter matches.
                    if ((tk_q[i] == serving_q) && !any_crit) begin
                        state_d[i] = CRIT;
                    end
                end
                CRIT: begin
                    if (rel[i]) begin
                        state_d[i] = IDLE;
                        serving_d  = serving_q + TKW'(1);
                    end else if (hold_expired) begin
                        state_d[i] = IDLE;
                        serving_d  = serving_q + TKW'(1);
                        perr_d     = 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (rel[i] && (state_q[i] != CRIT)) begin
                perr_d = 1'b1;
            end
        end

        // Outputs are registered copies of the next state decode.
        grant_d = '0;
        owner_d = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (state_d[i] == CRIT) begin
                grant_d[i] = 1'b1;
                owner_d    = IDW'(i);
            end
        end
        busy_d = |grant_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPROC; i++) begin
                state_q[i] <= IDLE;
            end
            tk_q      <= '0;
            next_tk_q <= '0;
            serving_q <= '0;
            grant_q   <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tk_q      <= tk_d;
            next_tk_q <= next_tk_d;
            serving_q <= serving_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            perr_q    <= perr_d;
        end
    end

    assign grant     = grant_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_bakery_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bakery_arbiter
// Directed bench for bakery_arbiter: a default instance (NPROC=4, TKW=4) and a
// small instance (NPROC=3, TKW=2) that exercises ticket wrap.
// -----------------------------------------------------------------------------
module tb_bakery_arbiter;

    logic       clock;
    logic       reset_n;
    logic [3:0] req, rel, grant;
    logic [1:0] owner;
    logic       busy, perr;
    logic [2:0] req_w, rel_w, grant_w;
    logic [1:0] owner_w;
    logic       busy_w, perr_w;

    int n_checks = 0;
    int n_fail   = 0;

    bakery_arbiter u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .rel       (rel),
        .grant     (grant),
        .owner     (owner),
        .busy      (busy),
        .proto_err (perr)
    );

    bakery_arbiter #(
        .NPROC (3),
        .TKW   (2),
        .IDW   (2)
    ) u_wrap (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req_w),
        .rel       (rel_w),
        .grant     (grant_w),
        .owner     (owner_w),
        .busy      (busy_w),
        .proto_err (perr_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Mutual exclusion on both instances, every cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("onehot", 32'($onehot0(grant)), 32'd1);
            chk("onehot_w", 32'($onehot0(grant_w)), 32'd1);
        end
    end

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic wrap_batch(input bit staggered);
        int ord[3];
        if (staggered) begin
            ord = '{2, 0, 1};
            req_w = 3'b100;
            tick();
            req_w = 3'b111;
            tick();
        end else begin
            ord = '{0, 1, 2};
            req_w = 3'b111;
            tick();
            tick();
        end
        for (int j = 0; j < 3; j++) begin
            chk("wrap_grant", 32'(grant_w), 32'(3'b001 << ord[j]));
            chk("wrap_owner", 32'(owner_w), 32'(ord[j]));
            req_w[ord[j]] = 1'b0;
            rel_w = 3'b001 << ord[j];
            tick();
            rel_w = 3'b000;
            chk("wrap_gap", 32'(grant_w), 32'd0);
            tick();
        end
        chk("wrap_busy", 32'(busy_w), 32'd0);
        chk("wrap_perr", 32'(perr_w), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        req = '0; rel = '0; req_w = '0; rel_w = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        reset_n = 1'b1;

        // Single requester
        req = 4'b0100;
        tick();
        chk("single_lat1", 32'(grant), 32'd0);
        chk("single_tk", 32'(u_dut.tk_q[2]), 32'd0);
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_owner", 32'(owner), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        repeat (3) tick();
        chk("single_hold", 32'(grant), 32'h4);
        rel = 4'b0100;
        tick();
        rel = 4'b0000;
        chk("single_rel", 32'(grant), 32'd0);
        chk("single_idle_owner", 32'(owner), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_serving", 32'(u_dut.serving_q), 32'd1);

        // Simultaneous arrivals: tickets 1..4 in index order
        req = 4'b1111;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("simul_tk", 32'(u_dut.tk_q[i]), 32'(i + 1));
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("simul_grant", 32'(grant), 32'(4'b0001 << k));
            chk("simul_owner", 32'(owner), 32'(k));
            req[k] = 1'b0;
            rel = 4'b0001 << k;
            tick();
            rel = 4'b0000;
            chk("simul_gap", 32'(grant), 32'd0);
            tick();
        end
        chk("simul_perr", 32'(perr), 32'd0);

        // Ticket order beats index order
        req = 4'b1000;
        tick();
        req = 4'b1001;
        tick();
        chk("order_first", 32'(grant), 32'h8);
        chk("order_owner", 32'(owner), 32'd3);
        req = 4'b0001;
        rel = 4'b1000;
        tick();
        rel = 4'b0000;
        chk("order_gap", 32'(grant), 32'd0);
        tick();
        chk("order_second", 32'(grant), 32'h1);
        req = 4'b0000;
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        chk("order_busy", 32'(busy), 32'd0);
        chk("order_perr", 32'(perr), 32'd0);

        // Release while idle
        rel = 4'b0010;
        tick();
        rel = 4'b0000;
        chk("relidle_perr", 32'(perr), 32'd1);
        chk("relidle_grant", 32'(grant), 32'd0);
        chk("relidle_busy", 32'(busy), 32'd0);

        // Asynchronous reset while a grant is held
        req = 4'b0001;
        tick();
        tick();
        chk("arst_pre", 32'(grant), 32'h1);
        req = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_owner", 32'(owner), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_perr", 32'(perr), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        tick();
        chk("arst_nogrant", 32'(grant), 32'd0);

        // req dropped while waiting: flagged, ticket kept
        req = 4'b0011;
        tick();
        tick();
        chk("drop_first", 32'(grant), 32'h1);
        chk("drop_perr0", 32'(perr), 32'd0);
        req = 4'b0000;
        tick();
        chk("drop_perr1", 32'(perr), 32'd1);
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        chk("drop_gap", 32'(grant), 32'd0);
        tick();
        chk("drop_grant", 32'(grant), 32'h2);
        rel = 4'b0010;
        tick();
        rel = 4'b0000;
        chk("drop_busy", 32'(busy), 32'd0);

        // Release and re-request in the same cycle: re-queues behind waiter
        req = 4'b0011;
        tick();
        tick();
        chk("rereq_first", 32'(grant), 32'h1);
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        chk("rereq_gap", 32'(grant), 32'd0);
        tick();
        chk("rereq_waiter", 32'(grant), 32'h2);
        req = 4'b0001;
        rel = 4'b0010;
        tick();
        rel = 4'b0000;
        tick();
        chk("rereq_again", 32'(grant), 32'h1);
        req = 4'b0000;
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
        chk("rereq_busy", 32'(busy), 32'd0);

`ifdef BAKERY_ARB_TIMEOUT_EN
        // Owner 1 never releases
        pulse_reset();
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0011;
        tick();
        chk("to_grant", 32'(grant), 32'h2);
        req = 4'b0001;
        repeat (14) tick();
        chk("to_hold", 32'(grant), 32'h2);
        chk("to_perr0", 32'(perr), 32'd0);
        tick();
        chk("to_forced", 32'(grant), 32'd0);
        chk("to_perr1", 32'(perr), 32'd1);
        tick();
        chk("to_next", 32'(grant), 32'h1);
        req = 4'b0000;
        rel = 4'b0001;
        tick();
        rel = 4'b0000;
`endif

        // Ticket wrap on the 3-requester, 2-bit-ticket instance
        for (int b = 0; b < 4; b++) begin
            wrap_batch(b[0]);
        end

        pulse_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
